// File: rtl/addr_reg_bank.sv
// Address register bank: PC/AR/SP plus general address registers, two combinational read ports,
// SP push/pop sequencer with sticky flags. Optional same-cycle load bypass: ARF_BYPASS_EN.
module addr_reg_bank #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      NREG     = 4,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter logic [WIDTH-1:0] SP_RESET = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] SP_LIMIT = 16'hFF00
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         I,
    input  logic [NREG-1:0]          RegEn,
    input  logic [2:0]               FunSel,
    input  logic [1:0]               StackOp,
    input  logic [$clog2(NREG)-1:0]  OutCSel,
    input  logic [$clog2(NREG)-1:0]  OutDSel,
    output logic [WIDTH-1:0]         OutC,
    output logic [WIDTH-1:0]         OutD,
    output logic                     SPOverflow,
    output logic                     SPUnderflow
);

    localparam int unsigned SELW   = $clog2(NREG);
    localparam int unsigned HALF   = WIDTH / 2;
    localparam int unsigned PC_IDX = 0;
    localparam int unsigned SP_IDX = 2;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] FS_HOLD = 3'b000;
    localparam logic [2:0] FS_CLR  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_INC  = 3'b011;
    localparam logic [2:0] FS_DEC  = 3'b100;
    localparam logic [2:0] FS_LOW  = 3'b101;
    localparam logic [2:0] FS_HIGH = 3'b110;
    localparam logic [2:0] FS_SEXT = 3'b111;

    localparam logic [1:0] SOP_NONE = 2'b00;
    localparam logic [1:0] SOP_PUSH = 2'b01;
    localparam logic [1:0] SOP_POP  = 2'b10;
    localparam logic [1:0] SOP_CLR  = 2'b11;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             sp_busy_s;
    logic [NREG-1:0]  byp_mask_s;

    // Next value of one register under a FunSel code; half-word ops use the low half of din.
    function automatic logic [WIDTH-1:0] apply_fun(
        input logic [2:0]       fs,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] r;
        case (fs)
            FS_HOLD: r = cur;
            FS_CLR:  r = '0;
            FS_LOAD: r = din;
            FS_INC:  r = cur + ONE;
            FS_DEC:  r = cur - ONE;
            FS_LOW:  r = {cur[WIDTH-1:HALF], din[HALF-1:0]};
            FS_HIGH: r = {din[HALF-1:0], cur[HALF-1:0]};
            FS_SEXT: r = {{HALF{din[HALF-1]}}, din[HALF-1:0]};
            default: r = cur;
        endcase
        return r;
    endfunction

    // Next-state: FunSel on enabled registers, then the stack sequencer owns SP on push/pop.
    always_comb begin
        regs_d    = regs_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        sp_busy_s = (StackOp == SOP_PUSH) || (StackOp == SOP_POP);
        for (int k = 0; k < int'(NREG); k++) begin
            if (RegEn[k] && !((k == int'(SP_IDX)) && sp_busy_s)) begin
                regs_d[k] = apply_fun(FunSel, regs_q[k], I);
            end else begin
                regs_d[k] = regs_q[k];
            end
        end
        case (StackOp)
            SOP_NONE: begin
                ovf_d = ovf_q;
            end
            SOP_PUSH: begin
                if (regs_q[SP_IDX] != SP_LIMIT) begin
                    regs_d[SP_IDX] = regs_q[SP_IDX] - ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            SOP_POP: begin
                if (regs_q[SP_IDX] != SP_RESET) begin
                    regs_d[SP_IDX] = regs_q[SP_IDX] + ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end
            SOP_CLR: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            default: begin
                ovf_d = ovf_q;
            end
        endcase
    end

    // State registers; reset overrides every operation in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < int'(NREG); k++) begin
                regs_q[k] <= '0;
            end
            regs_q[PC_IDX] <= PC_RESET;
            regs_q[SP_IDX] <= SP_RESET;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

`ifdef ARF_BYPASS_EN
    // Registers being loaded this cycle forward I straight to the read ports.
    always_comb begin
        if (!Reset && (FunSel == FS_LOAD)) begin
            byp_mask_s = RegEn;
        end else begin
            byp_mask_s = '0;
        end
    end
`else
    // No forwarding: ports always reflect registered state.
    always_comb begin
        byp_mask_s = '0;
    end
`endif

    // Read muxes; selects beyond the register count read as zero.
    always_comb begin
        OutC = '0;
        OutD = '0;
        for (int k = 0; k < int'(NREG); k++) begin
            OutC = (OutCSel == SELW'(k)) ? (byp_mask_s[k] ? I : regs_q[k]) : OutC;
            OutD = (OutDSel == SELW'(k)) ? (byp_mask_s[k] ? I : regs_q[k]) : OutD;
        end
    end

    assign SPOverflow  = ovf_q;
    assign SPUnderflow = unf_q;

endmodule
